hazard_stall_unit: RTL and testbench

//  Producer-side companion to the EX-stage forwarding logic. Covers the hazards forwarding cannot

---
 rtl/hazard_stall_unit.sv | 122 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / taken-branch / memory-wait stall and flush control
//
// Purpose: resolves the pipeline hazards that EX-stage forwarding cannot. A load whose
// result is needed by the instruction in ID stalls IF/ID and bubbles ID/EX for LOAD_LAT
// cycles. A taken branch in EX flushes IF/ID and bubbles ID/EX. A busy data memory
// freezes the back end of the pipe. Control outputs are combinational; the stall FSM and
// the saturating perf counters update on the rising clock edge.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   IFID_Rs1/Rs2      source registers of the ID instruction
//   IFID_UsesRs1/Rs2  ID instruction actually reads that source
//   IDEX_rd           destination register of the EX instruction
//   IDEX_MemRead      EX instruction is a load
//   EX_BranchTaken    branch/jump in EX resolved taken
//   mem_busy          data memory not ready this cycle
//   pc_write          PC may update
//   IFID_Write        IF/ID may load
//   IFID_Flush        IF/ID loads a NOP
//   IDEX_Bubble       ID/EX loads zeroed control
//   pipe_freeze       ID/EX, EX/MEM, MEM/WB hold
//   stall_cnt         load-use stall cycles, saturating
//   flush_cnt         taken-branch flush events, saturating

module hazard_stall_unit #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             IFID_UsesRs1,
  input  logic             IFID_UsesRs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0]       REM_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic [3:0] remaining;
  logic       hazard;
  logic       stall_now;

  // Only looked at in RUN: once stalling, the bubble in EX clears IDEX_MemRead anyway,
  // so the remaining count alone decides how long the stall lasts.
  always_comb begin
    hazard = (state == RUN) && IDEX_MemRead && (IDEX_rd != 5'd0) &&
             ((IFID_UsesRs1 && (IDEX_rd == IFID_Rs1)) ||
              (IFID_UsesRs2 && (IDEX_rd == IFID_Rs2)));
  end

  assign stall_now = (state == STALL) || hazard;

  // Priority: reset > mem_busy > taken branch > load-use stall > free run.
  always_comb begin
    pc_write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      IFID_Write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stall_now) begin
      pc_write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end
  end

  // A frozen cycle changes nothing, so a stall always spans exactly LOAD_LAT
  // unfrozen cycles no matter how long the memory holds the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      remaining <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (EX_BranchTaken) begin
        // The ID instruction is wrong-path, so any pending stall is moot.
        state     <= RUN;
        remaining <= 4'd0;
        if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (state == STALL) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
        remaining <= remaining - 4'd1;
        if (remaining == 4'd1) state <= RUN;
      end else if (hazard) begin
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
        if (LOAD_LAT > 1) begin
          state     <= STALL;
          remaining <= REM_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized and directed bench for hazard_stall_unit

module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, memrd, br, busy;

  logic        pw0, iw0, ifl0, ib0, pf0;
  logic [15:0] sc0, fc0;
  logic        pw1, iw1, ifl1, ib1, pf1;
  logic [15:0] sc1, fc1;
  logic        pw2, iw2, ifl2, ib2, pf2;
  logic [1:0]  sc2, fc2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per instance, the number of stall cycles still owed.
  int ll [3] = '{1, 3, 3};
  int cw [3] = '{16, 16, 2};
  int left [3];
  int scnt [3];
  int fcnt [3];

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .IFID_Rs1(rs1), .IFID_Rs2(rs2), .IFID_UsesRs1(u1),
    .IFID_UsesRs2(u2), .IDEX_rd(rd), .IDEX_MemRead(memrd), .EX_BranchTaken(br),
    .mem_busy(busy), .pc_write(pw0), .IFID_Write(iw0), .IFID_Flush(ifl0),
    .IDEX_Bubble(ib0), .pipe_freeze(pf0), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_stall_unit #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .IFID_Rs1(rs1), .IFID_Rs2(rs2), .IFID_UsesRs1(u1),
    .IFID_UsesRs2(u2), .IDEX_rd(rd), .IDEX_MemRead(memrd), .EX_BranchTaken(br),
    .mem_busy(busy), .pc_write(pw1), .IFID_Write(iw1), .IFID_Flush(ifl1),
    .IDEX_Bubble(ib1), .pipe_freeze(pf1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_stall_unit #(.LOAD_LAT(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .IFID_Rs1(rs1), .IFID_Rs2(rs2), .IFID_UsesRs1(u1),
    .IFID_UsesRs2(u2), .IDEX_rd(rd), .IDEX_MemRead(memrd), .EX_BranchTaken(br),
    .mem_busy(busy), .pc_write(pw2), .IFID_Write(iw2), .IFID_Flush(ifl2),
    .IDEX_Bubble(ib2), .pipe_freeze(pf2), .stall_cnt(sc2), .flush_cnt(fc2));

  function automatic bit hz_in();
    return memrd && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  // {pc_write, IFID_Write, IFID_Flush, IDEX_Bubble, pipe_freeze, stall_cnt, flush_cnt}
  function automatic logic [36:0] exp_vec(int k);
    logic [4:0] c;
    if (reset)                    return {5'b00110, 32'd0};
    else if (busy)                c = 5'b00001;
    else if (br)                  c = 5'b11110;
    else if (left[k] > 0 || hz_in()) c = 5'b00010;
    else                          c = 5'b11000;
    return {c, 16'(scnt[k]), 16'(fcnt[k])};
  endfunction

  function automatic logic [36:0] got_vec(int k);
    case (k)
      0:       return {pw0, iw0, ifl0, ib0, pf0, sc0, fc0};
      1:       return {pw1, iw1, ifl1, ib1, pf1, sc1, fc1};
      default: return {pw2, iw2, ifl2, ib2, pf2, 14'd0, sc2, 14'd0, fc2};
    endcase
  endfunction

  function automatic int sat_inc(int v, int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic model_tick();
    bit h;
    h = hz_in();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else if (busy) begin
      end else if (br) begin
        left[k] = 0;
        fcnt[k] = sat_inc(fcnt[k], cw[k]);
      end else if (left[k] > 0) begin
        left[k]--;
        scnt[k] = sat_inc(scnt[k], cw[k]);
      end else if (h) begin
        left[k] = ll[k] - 1;
        scnt[k] = sat_inc(scnt[k], cw[k]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; memrd = 1'b0; br = 1'b0; busy = 1'b0;
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    u1 = 1'($urandom); u2 = 1'($urandom);
  endtask

  task automatic load_use(logic [4:0] r);
    idle();
    memrd = 1'b1; rd = r; rs1 = r; u1 = 1'b1; rs2 = r + 5'd1; u2 = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      reset = 1'b1; memrd = 1'($urandom); br = 1'($urandom); busy = 1'($urandom);
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset inst%0d t=%0t got=%h exp=%h", k, $time, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  // One hazard cycle, then the load leaves EX; LOAD_LAT=1 stalls once, LOAD_LAT=3 three times.
  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0) load_use(5'd5); else idle();
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL load_use c%0d inst%0d got=%h exp=%h", c, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    n_vec++;
    if (sc0 !== 16'd1 || sc1 !== 16'd3) begin
      n_err++;
      $display("FAIL load_use_cnt got=%0d/%0d exp=1/3", sc0, sc1);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      idle();
      memrd = 1'b1;
      if (c == 0) begin rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; end
      else begin rd = 5'd7; rs2 = 5'd7; u2 = 1'b0; rs1 = 5'd8; u1 = 1'b1; end
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== {5'b11000, 32'd0}) begin
          n_err++;
          $display("FAIL no_hazard c%0d inst%0d got=%h exp=%h", c, k, got_vec(k), {5'b11000, 32'd0});
        end
      end
      tick();
    end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin load_use(5'd9); br = 1'b1; end else idle();
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL branch c%0d inst%0d got=%h exp=%h", c, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    n_vec++;
    if (sc1 !== 16'd0 || fc1 !== 16'd1 || pw1 !== 1'b1) begin
      n_err++;
      $display("FAIL branch_cnt got=%0d/%0d/%b exp=0/1/1", sc1, fc1, pw1);
    end
  endtask

  task automatic test_mem_busy();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 0) load_use(5'd12);
      else begin idle(); busy = (c == 1 || c == 2); end
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL mem_busy c%0d inst%0d got=%h exp=%h", c, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    n_vec++;
    if (sc1 !== 16'd3) begin
      n_err++;
      $display("FAIL mem_busy_cnt got=%0d exp=3", sc1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int h = 0; h < 5; h++) begin
      for (int c = 0; c < 5; c++) begin
        if (c == 0) load_use(5'(h + 1)); else idle();
        #2;
        for (int k = 0; k < 3; k++) begin
          n_vec++;
          if (got_vec(k) !== exp_vec(k)) begin
            n_err++;
            $display("FAIL saturate h%0d c%0d inst%0d got=%h exp=%h", h, c, k, got_vec(k), exp_vec(k));
          end
        end
        tick();
      end
    end
    n_vec++;
    if (sc2 !== 2'd3 || sc0 !== 16'd5) begin
      n_err++;
      $display("FAIL saturate_cnt got=%0d/%0d exp=3/5", sc2, sc0);
    end
    // Reset while the LOAD_LAT=3 instances are mid-stall.
    load_use(5'd4);
    tick();
    idle();
    reset = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got_vec(k) !== {5'b00110, 32'd0}) begin
        n_err++;
        $display("FAIL reset_mid_stall inst%0d got=%h exp=%h", k, got_vec(k), {5'b00110, 32'd0});
      end
    end
    tick();
    idle();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got_vec(k) !== {5'b11000, 32'd0}) begin
        n_err++;
        $display("FAIL after_reset inst%0d got=%h exp=%h", k, got_vec(k), {5'b11000, 32'd0});
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      u1    = 1'($urandom);
      u2    = 1'($urandom);
      memrd = ($urandom_range(0, 99) < 50);
      br    = ($urandom_range(0, 99) < 10);
      busy  = ($urandom_range(0, 99) < 20);
      #2;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random c%0d inst%0d got=%h exp=%h", c, k, got_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin left[k] = 0; scnt[k] = 0; fcnt[k] = 0; end
    idle();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_vs_hazard();
    test_mem_busy();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
